fm_mpx_step_gen: RTL and testbench

Parametrised stereo-multiplex composer and DDS step generator for the all-digital FM modulator. It combines the L−R channel on the 38 kHz subcarrier, the scaled 19 kHz pilot and the L+R channel into one composite MPX sample. It then scales the sample by the frequency-deviation gain and adds the carrier phase step. Each input sample is processed through a 4-stage pipeline. Coefficients are runtime-programmable through shadow registers, and the resulting step feeds the RF DDS phase accumulator.

---
 rtl/fm_mpx_step_gen_if.sv | 36 +++
 rtl/fm_mpx_step_gen.sv | 183 ++++++++++++++++++
 tb/tb_fm_mpx_step_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fm_mpx_step_gen_if.sv
`default_nettype none
// ===========================================================================
// Module  : fm_mpx_step_gen_if
// Purpose : sample / configuration / step bundle of the MPX step generator
// Rev     : 1.0
// ===========================================================================
interface fm_mpx_step_gen_if #(
    parameter int SW    = 18,
    parameter int CW    = 10,
    parameter int STEPW = 30
) ();
    logic                    sample_en;
    logic signed [SW-1:0]    lmr;
    logic signed [SW-1:0]    lpr;
    logic signed [CW-1:0]    dds_f19;
    logic signed [CW-1:0]    dds_f38;
    logic                    mute;
    logic                    cfg_we;
    logic [1:0]              cfg_addr;
    logic [STEPW-1:0]        cfg_data;
    logic [STEPW-1:0]        step;
    logic                    step_valid;

    modport master (
        output sample_en, lmr, lpr, dds_f19, dds_f38, mute,
        output cfg_we, cfg_addr, cfg_data,
        input  step, step_valid
    );

    modport slave (
        input  sample_en, lmr, lpr, dds_f19, dds_f38, mute,
        input  cfg_we, cfg_addr, cfg_data,
        output step, step_valid
    );
endinterface
`default_nettype wire

// File: rtl/fm_mpx_step_gen.sv
`default_nettype none
// ===========================================================================
// Module  : fm_mpx_step_gen
// Purpose : stereo MPX composer + deviation scaling into a DDS phase step;
//           define FM_MPX_SAT_EN for saturating reductions (default wraps).
// Rev     : 1.0
// ===========================================================================
module fm_mpx_step_gen #(
    parameter int          SW           = 18,
    parameter int          CW           = 10,
    parameter int          KW           = 8,
    parameter int          STEPW        = 30,
    parameter int unsigned CARRIER_INIT = 0,
    parameter int unsigned KP_INIT      = 26,
    parameter int unsigned KF_INIT      = 1
) (
    input  logic             clock,
    input  logic             reset,
    fm_mpx_step_gen_if.slave bus
);
    localparam int SUBW = SW + CW;
    localparam int PILW = SW + KW + 1;
    localparam int DEVW = SW + KW;
    localparam int SUMW = STEPW + 2;

    logic [STEPW-1:0]     carrier_sh_q, carrier_sh_d, carrier_act_q, carrier_act_d;
    logic [KW-1:0]        kp_sh_q, kp_sh_d, kp_act_q, kp_act_d;
    logic [KW-1:0]        kf_sh_q, kf_sh_d, kf_act_q, kf_act_d;
    logic                 commit_pending_q, commit_pending_d;
    logic                 commit;
    logic [STEPW-1:0]     carrier_use;
    logic [KW-1:0]        kp_use, kf_use;

    logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, step_valid_q, step_valid_d;
    logic signed [SW:0]   sub_q, sub_d, pil_q, pil_d;
    logic signed [SW-1:0] lpr_q, lpr_d, mpx_q, mpx_d;
    logic                 mute_q, mute_d;
    logic [KW-1:0]        kf1_q, kf1_d, kf2_q, kf2_d;
    logic [STEPW-1:0]     car1_q, car1_d, car2_q, car2_d, car3_q, car3_d;
    logic signed [DEVW-1:0] dev_q, dev_d;
    logic [STEPW-1:0]     step_q, step_d;

    logic signed [SW-1:0]   f19_sh;
    logic signed [SUBW-1:0] sub_prod;
    logic signed [PILW-1:0] pil_prod;
    logic signed [SW+1:0]   mpx_sum;
    logic signed [SW-1:0]   mpx_red;
    logic signed [DEVW-1:0] dev_prod;
    logic signed [SUMW-1:0] step_sum;
    logic [STEPW-1:0]       step_red;

`ifdef FM_MPX_SAT_EN
    localparam logic signed [SW+1:0] MPX_MAX = (SW+2)'(2**(SW-1) - 1);
    localparam logic signed [SW+1:0] MPX_MIN = (SW+2)'(-(2**(SW-1)));
`endif

    // The committing sample itself already sees the shadow values, so an
    // in-flight write on the same cycle cannot leak into this commit.
    assign commit      = bus.sample_en & commit_pending_q;
    assign carrier_use = commit ? carrier_sh_q : carrier_act_q;
    assign kp_use      = commit ? kp_sh_q      : kp_act_q;
    assign kf_use      = commit ? kf_sh_q      : kf_act_q;

    always_comb begin
        carrier_sh_d     = carrier_sh_q;
        kp_sh_d          = kp_sh_q;
        kf_sh_d          = kf_sh_q;
        carrier_act_d    = carrier_use;
        kp_act_d         = kp_use;
        kf_act_d         = kf_use;
        commit_pending_d = commit_pending_q & ~bus.sample_en;
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                2'd0:    carrier_sh_d     = bus.cfg_data;
                2'd1:    kp_sh_d          = bus.cfg_data[KW-1:0];
                2'd2:    kf_sh_d          = bus.cfg_data[KW-1:0];
                default: commit_pending_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        f19_sh   = SW'(bus.dds_f19) <<< (SW - CW);
        sub_prod = SUBW'(bus.lmr) * SUBW'(bus.dds_f38);
        pil_prod = PILW'(f19_sh) * PILW'($signed({1'b0, kp_use}));
        mpx_sum  = (SW+2)'(sub_q) + (SW+2)'(pil_q) + (SW+2)'(lpr_q);
        dev_prod = DEVW'(mpx_q) * DEVW'($signed({1'b0, kf2_q}));
        step_sum = $signed({2'b00, car3_q}) + SUMW'(dev_q);
`ifdef FM_MPX_SAT_EN
        if (mpx_sum > MPX_MAX)
            mpx_red = SW'(MPX_MAX);
        else if (mpx_sum < MPX_MIN)
            mpx_red = SW'(MPX_MIN);
        else
            mpx_red = SW'(mpx_sum);
        if (step_sum[SUMW-1])
            step_red = '0;
        else if (step_sum[STEPW])
            step_red = '1;
        else
            step_red = step_sum[STEPW-1:0];
`else
        mpx_red  = SW'(mpx_sum);
        step_red = STEPW'(step_sum);
`endif
    end

    // Each stage only advances when the sample ahead of it is valid.
    always_comb begin
        v1_d         = bus.sample_en;
        v2_d         = v1_q;
        v3_d         = v2_q;
        step_valid_d = v3_q;
        sub_d  = bus.sample_en ? (SW+1)'(sub_prod >>> (CW - 1)) : sub_q;
        pil_d  = bus.sample_en ? (SW+1)'(pil_prod >>> KW)       : pil_q;
        lpr_d  = bus.sample_en ? bus.lpr     : lpr_q;
        mute_d = bus.sample_en ? bus.mute    : mute_q;
        kf1_d  = bus.sample_en ? kf_use      : kf1_q;
        car1_d = bus.sample_en ? carrier_use : car1_q;
        mpx_d  = v1_q ? (mute_q ? '0 : mpx_red) : mpx_q;
        kf2_d  = v1_q ? kf1_q    : kf2_q;
        car2_d = v1_q ? car1_q   : car2_q;
        dev_d  = v2_q ? dev_prod : dev_q;
        car3_d = v2_q ? car2_q   : car3_q;
        step_d = v3_q ? step_red : step_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            carrier_sh_q     <= STEPW'(CARRIER_INIT);
            carrier_act_q    <= STEPW'(CARRIER_INIT);
            kp_sh_q          <= KW'(KP_INIT);
            kp_act_q         <= KW'(KP_INIT);
            kf_sh_q          <= KW'(KF_INIT);
            kf_act_q         <= KW'(KF_INIT);
            commit_pending_q <= 1'b0;
            v1_q             <= 1'b0;
            v2_q             <= 1'b0;
            v3_q             <= 1'b0;
            step_valid_q     <= 1'b0;
            sub_q            <= '0;
            pil_q            <= '0;
            lpr_q            <= '0;
            mute_q           <= 1'b0;
            kf1_q            <= '0;
            car1_q           <= '0;
            mpx_q            <= '0;
            kf2_q            <= '0;
            car2_q           <= '0;
            dev_q            <= '0;
            car3_q           <= '0;
            step_q           <= '0;
        end else begin
            carrier_sh_q     <= carrier_sh_d;
            carrier_act_q    <= carrier_act_d;
            kp_sh_q          <= kp_sh_d;
            kp_act_q         <= kp_act_d;
            kf_sh_q          <= kf_sh_d;
            kf_act_q         <= kf_act_d;
            commit_pending_q <= commit_pending_d;
            v1_q             <= v1_d;
            v2_q             <= v2_d;
            v3_q             <= v3_d;
            step_valid_q     <= step_valid_d;
            sub_q            <= sub_d;
            pil_q            <= pil_d;
            lpr_q            <= lpr_d;
            mute_q           <= mute_d;
            kf1_q            <= kf1_d;
            car1_q           <= car1_d;
            mpx_q            <= mpx_d;
            kf2_q            <= kf2_d;
            car2_q           <= car2_d;
            dev_q            <= dev_d;
            car3_q           <= car3_d;
            step_q           <= step_d;
        end
    end

    assign bus.step       = step_q;
    assign bus.step_valid = step_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_fm_mpx_step_gen.sv
`default_nettype none
// ===========================================================================
// Module  : tb_fm_mpx_step_gen
// Purpose : directed self-checking bench for fm_mpx_step_gen
// Rev     : 1.0
// ===========================================================================
module tb_fm_mpx_step_gen;
    localparam int SW    = 18;
    localparam int CW    = 10;
    localparam int KW    = 8;
    localparam int STEPW = 30;
    localparam logic [63:0] C_CAR = 64'h100_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fm_mpx_step_gen_if #(.SW(SW), .CW(CW), .STEPW(STEPW)) bus ();

    fm_mpx_step_gen #(
        .SW(SW), .CW(CW), .KW(KW), .STEPW(STEPW),
        .CARRIER_INIT(0), .KP_INIT(26), .KF_INIT(1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;
    logic [63:0] exp_q[$];
    int          expc_q[$];

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Every step_valid pulse must match the oldest outstanding expectation,
    // both in value and in the cycle it appears.
    always @(negedge clock) begin
        if (bus.step_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {63'd0, bus.step_valid}, 64'd0);
            end else begin
                chk("step", {34'd0, bus.step}, exp_q.pop_front());
                chk("latency", 64'(cyc_cnt), 64'(expc_q.pop_front()));
            end
        end
    end

    task automatic cyc(input logic en, input int lmr, input int lpr, input int f19, input int f38,
                       input logic mute, input logic we, input logic [1:0] addr, input int data,
                       input logic track, input logic [63:0] exp);
        @(negedge clock);
        bus.sample_en = en;
        bus.lmr       = SW'(lmr);
        bus.lpr       = SW'(lpr);
        bus.dds_f19   = CW'(f19);
        bus.dds_f38   = CW'(f38);
        bus.mute      = mute;
        bus.cfg_we    = we;
        bus.cfg_addr  = addr;
        bus.cfg_data  = STEPW'(data);
        if (en && track) begin
            exp_q.push_back(exp);
            expc_q.push_back(cyc_cnt + 4);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 64'd0);
    endtask

    task automatic wr(input logic [1:0] addr, input int data);
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, addr, data, 1'b0, 64'd0);
    endtask

    task automatic smp(input int lmr, input int lpr, input int f19, input int f38,
                       input logic mute, input logic [63:0] exp);
        cyc(1'b1, lmr, lpr, f19, f38, mute, 1'b0, 2'd0, 0, 1'b1, exp);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 6; i++) idle();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.lmr = '0; bus.lpr = '0; bus.dds_f19 = '0; bus.dds_f38 = '0;
        bus.mute = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;

        for (int i = 0; i < 3; i++) idle();
        chk("reset_step", {34'd0, bus.step}, 64'd0);
        chk("reset_valid", {63'd0, bus.step_valid}, 64'd0);
        reset = 1'b0;

        // Carrier written to shadow only: output still uses carrier 0.
        wr(2'd0, 32'h100_0000);
        smp(0, 0, 0, 0, 1'b0, 64'd0);
        drain("no_commit_drained");
        wr(2'd3, 0);
        smp(0, 0, 0, 0, 1'b0, C_CAR);
        drain("carrier_drained");
        chk("step_hold", {34'd0, bus.step}, C_CAR);
        chk("valid_low", {63'd0, bus.step_valid}, 64'd0);

        // Pilot: (256<<8)*128>>8 = 32768.
        wr(2'd1, 128); wr(2'd3, 0);
        smp(0, 0, 256, 0, 1'b0, C_CAR + 64'd32768);

        // Subcarrier: 65536*-512>>>9 = -65536, times kf=2.
        wr(2'd1, 0); wr(2'd2, 2); wr(2'd3, 0);
        smp(65536, 0, 0, -512, 1'b0, C_CAR - 64'd131072);

        // MPX overflow: 130815 + 131071 = 261886 exceeds 18-bit range.
        wr(2'd2, 1); wr(2'd3, 0);
`ifdef FM_MPX_SAT_EN
        smp(131071, 131071, 0, 511, 1'b0, C_CAR + 64'd131071);
`else
        smp(131071, 131071, 0, 511, 1'b0, C_CAR - 64'd258);
`endif
        smp(131071, 131071, 0, 511, 1'b1, C_CAR);
        drain("paths_drained");

        // Step overflow and negative step.
        wr(2'd0, 32'h3FFF_FFFF); wr(2'd3, 0);
`ifdef FM_MPX_SAT_EN
        smp(0, 100, 0, 0, 1'b0, 64'h3FFF_FFFF);
`else
        smp(0, 100, 0, 0, 1'b0, 64'd99);
`endif
        wr(2'd0, 0); wr(2'd3, 0);
`ifdef FM_MPX_SAT_EN
        smp(0, -1000, 0, 0, 1'b0, 64'd0);
`else
        smp(0, -1000, 0, 0, 1'b0, 64'h4000_0000 - 64'd1000);
`endif
        drain("clamp_drained");

        // Shadow kf=4 not yet active; commit lands while 3 samples in flight.
        wr(2'd2, 4);
        smp(0, 1000, 0, 0, 1'b0, 64'd1000);
        smp(0, 1000, 0, 0, 1'b0, 64'd1000);
        smp(0, 1000, 0, 0, 1'b0, 64'd1000);
        smp(0, 1000, 0, 0, 1'b0, 64'd1000);
        wr(2'd3, 0);
        smp(0, 1000, 0, 0, 1'b0, 64'd4000);

        // Write on the commit boundary stays in the shadow.
        wr(2'd2, 3); wr(2'd3, 0);
        cyc(1'b1, 0, 1000, 0, 0, 1'b0, 1'b1, 2'd2, 5, 1'b1, 64'd3000);
        smp(0, 1000, 0, 0, 1'b0, 64'd3000);
        wr(2'd3, 0);
        idle(); idle();
        smp(0, 1000, 0, 0, 1'b0, 64'd5000);
        drain("commit_drained");

        // Reset while three samples are in flight: none may emerge.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 0, 1000, 0, 0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 64'd0);
        idle();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        drain("reset_drained");
        chk("step_after_reset", {34'd0, bus.step}, 64'd0);
        chk("valid_after_reset", {63'd0, bus.step_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
